if_id_fetch_queue: RTL and testbench

//  - Parametrised instruction buffer between if_stage and id_stage.
//  - Replaces the fixed single-entry IF/ID latch with a DEPTH-entry FIFO.
//  - Lets fetch run ahead while ID stalls.
//  - Drops all entries on flush (branch/jump/exception redirect).

---
 rtl/if_id_fetch_queue_pkg.sv | 29 ++
 rtl/if_id_fetch_queue_if.sv | 48 ++++
 rtl/if_id_fetch_queue_ram.sv | 38 +++
 rtl/if_id_fetch_queue.sv | 148 ++++++++++++++
 tb/tb_if_id_fetch_queue.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_id_fetch_queue_pkg
// Shared definitions for the IF/ID fetch queue slice and the pipeline stages
// around it (if_stage / id_stage reuse the flush-source encodings).
//   XLEN_DEFAULT   default data/pc width
//   DEPTH_DEFAULT  default number of queue entries
//   NOP_INSTR      instruction presented when no entry is valid (addi x0,x0,0)
//   flush_src_e    encoding of who requested a front-end redirect
// -----------------------------------------------------------------------------
package if_id_fetch_queue_pkg;

  localparam int          XLEN_DEFAULT  = 32;
  localparam int          DEPTH_DEFAULT = 4;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  // Redirect sources; any value other than FLUSH_NONE empties the queue.
  typedef enum logic [1:0] {
    FLUSH_NONE   = 2'd0,
    FLUSH_BRANCH = 2'd1,
    FLUSH_JUMP   = 2'd2,
    FLUSH_EXC    = 2'd3
  } flush_src_e;

  // Converts a redirect source into the single-bit flush request.
  function automatic logic is_redirect(input flush_src_e src);
    return (src != FLUSH_NONE);
  endfunction

endpackage

// File: rtl/if_id_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// if_id_fetch_queue_if
// Handshake bundle between if_stage (enqueue side), id_stage (dequeue side)
// and the fetch queue. Signal names keep the _i/_o suffixes as seen from the
// queue so the wiring reads the same as the queue's port list.
//   master modport : pipeline side (drives flush, enqueue payload, deq_ready_i)
//   slave modport  : the queue itself
//   Enqueue : enq_valid_i, enq_ready_o, enq_pc_i, enq_instr_i, enq_exc_i
//   Dequeue : deq_valid_o, deq_ready_i, deq_pc_o, deq_pc_add4_o,
//             deq_instr_o, deq_exc_o
//   Status  : count_o (occupancy 0..DEPTH), flush_i (redirect)
// -----------------------------------------------------------------------------
interface if_id_fetch_queue_if
  import if_id_fetch_queue_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush_i;
  logic            enq_valid_i;
  logic            enq_ready_o;
  logic [XLEN-1:0] enq_pc_i;
  logic [31:0]     enq_instr_i;
  logic            enq_exc_i;
  logic            deq_valid_o;
  logic            deq_ready_i;
  logic [XLEN-1:0] deq_pc_o;
  logic [XLEN-1:0] deq_pc_add4_o;
  logic [31:0]     deq_instr_o;
  logic            deq_exc_o;
  logic [CW-1:0]   count_o;

  modport master (
    output flush_i, enq_valid_i, enq_pc_i, enq_instr_i, enq_exc_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_pc_o, deq_pc_add4_o, deq_instr_o,
           deq_exc_o, count_o
  );

  modport slave (
    input  flush_i, enq_valid_i, enq_pc_i, enq_instr_i, enq_exc_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_pc_o, deq_pc_add4_o, deq_instr_o,
           deq_exc_o, count_o
  );

endinterface

// File: rtl/if_id_fetch_queue_ram.sv
// -----------------------------------------------------------------------------
// fetch_queue_ram
// DEPTH x WIDTH register array holding queued {pc, instr, exc} entries.
// One synchronous write port, one asynchronous read port. Contents are not
// reset; the queue's output muxing hides stale data.
//   clk    clock
//   we     write enable
//   waddr  write index
//   wdata  entry to store
//   raddr  read index
//   rdata  entry at raddr (combinational)
// -----------------------------------------------------------------------------
module fetch_queue_ram
  import if_id_fetch_queue_pkg::*;
#(
  parameter int WIDTH = XLEN_DEFAULT + 33,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_id_fetch_queue
// DEPTH-entry instruction FIFO between if_stage and id_stage, replacing the
// single IF/ID latch so fetch can run ahead while ID stalls. A flush drops
// every entry at the next edge and masks the head in the flush cycle.
//   clk  clock, all state on the rising edge
//   rst  asynchronous active-high reset (pointers, count, held pc only)
//   q    if_id_fetch_queue_if.slave: enqueue/dequeue handshakes, flush,
//        head pc / pc+4 / instruction / exception flag, occupancy count
// Optional feature macro FETCH_QUEUE_BYPASS_EN: when the queue is empty an
// incoming instruction is presented on deq_* in the same cycle, and is not
// written at all if ID takes it immediately. Without the macro there is no
// combinational path from enq_* to deq_* and the minimum latency is 1 cycle.
// -----------------------------------------------------------------------------
module if_id_fetch_queue
  import if_id_fetch_queue_pkg::*;
#(
  parameter int          XLEN  = XLEN_DEFAULT,
  parameter int          DEPTH = DEPTH_DEFAULT,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input logic               clk,
  input logic               rst,
  if_id_fetch_queue_if.slave q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = XLEN + 32 + 1;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] last_pc;

  logic            full;
  logic            empty;
  logic            bypass_active;
  logic            bypass_consume;
  logic            head_valid;
  logic            enq_fire;
  logic            deq_fire;
  logic            wr_en;
  logic            rd_adv;
  logic [EW-1:0]   wr_data;
  logic [EW-1:0]   rd_data;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  logic            head_exc;
  logic [XLEN-1:0] pc_out;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_active = empty & q.enq_valid_i & ~q.flush_i;
`else
  assign bypass_active = 1'b0;
`endif

  // A bypassed entry taken by ID in the same cycle never touches storage or
  // the pointers; otherwise bypass behaves like a normal enqueue.
  assign bypass_consume = bypass_active & q.deq_ready_i;

  // Head is valid when something is stored or bypassed; flush masks it so
  // ID never consumes an instruction from the wrong path.
  assign head_valid = ~q.flush_i & (~empty | bypass_active);

  // Full refuses enqueue even when a dequeue happens in the same cycle, which
  // keeps enq_ready_o purely registered.
  assign enq_fire = q.enq_valid_i & ~full & ~q.flush_i;
  assign deq_fire = head_valid & q.deq_ready_i;
  assign wr_en    = enq_fire & ~bypass_consume;
  assign rd_adv   = deq_fire & ~bypass_consume;

  assign wr_data = {q.enq_pc_i, q.enq_instr_i, q.enq_exc_i};

  fetch_queue_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Head entry selection: stored head, or the incoming fetch when bypassing.
  always_comb begin
    head_pc    = rd_data[EW-1 -: XLEN];
    head_instr = rd_data[32:1];
    head_exc   = rd_data[0];
    if (bypass_active) begin
      head_pc    = q.enq_pc_i;
      head_instr = q.enq_instr_i;
      head_exc   = q.enq_exc_i;
    end
  end

  // When nothing is present the pc outputs hold whatever was last shown.
  assign pc_out = (~empty | bypass_active) ? head_pc : last_pc;

  assign q.enq_ready_o   = ~full;
  assign q.deq_valid_o   = head_valid;
  assign q.deq_pc_o      = pc_out;
  assign q.deq_pc_add4_o = pc_out + XLEN'(4);
  assign q.deq_instr_o   = head_valid ? head_instr : NOP;
  assign q.deq_exc_o     = head_valid & head_exc;
  assign q.count_o       = count;

  // Pointer and occupancy bookkeeping; flush wins over any handshake and
  // pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !rd_adv) begin
        count <= count + CW'(1);
      end else if (rd_adv && !wr_en) begin
        count <= count - CW'(1);
      end
    end
  end

  // Remembers the displayed pc so it can be held while the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc <= '0;
    end else begin
      last_pc <= pc_out;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_id_fetch_queue
// Self-checking bench for if_id_fetch_queue: a directed vector table, a few
// hand-written multi-cycle sequences (async reset, simultaneous enq/deq,
// flush, bypass latency) and a randomized run against a queue-based model.
// Honours FETCH_QUEUE_BYPASS_EN when the build defines it.
// -----------------------------------------------------------------------------
module tb_if_id_fetch_queue;
  import if_id_fetch_queue_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  if_id_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq_if ();

  if_id_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (fq_if)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] add4;
    logic [31:0] instr;
    logic        exc;
    logic [2:0]  count;
    logic        ready;
  } exp_t;

  typedef struct packed {
    logic        flush;
    logic        ev;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic        dr;
    exp_t        e;
  } vec_t;

  entry_t      model_q[$];
  logic [31:0] model_last_pc;
  exp_t        cur_e;
  vec_t        vecs[13];
  int          errors = 0;
  int          checks = 0;

  function automatic exp_t mk_exp(input logic v, input logic [31:0] pc,
                                  input logic [31:0] instr, input logic exc,
                                  input logic [2:0] cnt, input logic rdy);
    exp_t e;
    e.valid = v;
    e.pc    = pc;
    e.add4  = pc + 32'd4;
    e.instr = instr;
    e.exc   = exc;
    e.count = cnt;
    e.ready = rdy;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic fl, input logic ev,
                                  input logic [31:0] pc, input logic [31:0] instr,
                                  input logic exc, input logic dr, input exp_t e);
    vec_t v;
    v.flush = fl;
    v.ev    = ev;
    v.pc    = pc;
    v.instr = instr;
    v.exc   = exc;
    v.dr    = dr;
    v.e     = e;
    return v;
  endfunction

  // Expected outputs for the current inputs, derived from queue contents.
  function automatic exp_t model_predict();
    exp_t   e;
    entry_t head;
    bit     byp;
    int     n;
    n   = model_q.size();
    byp = BYP && !fq_if.flush_i && (n == 0) && fq_if.enq_valid_i;
    if (n > 0) head = model_q[0];
    else head = '{pc: fq_if.enq_pc_i, instr: fq_if.enq_instr_i, exc: fq_if.enq_exc_i};
    e.valid = !fq_if.flush_i && ((n > 0) || byp);
    e.pc    = ((n > 0) || byp) ? head.pc : model_last_pc;
    e.add4  = e.pc + 32'd4;
    e.instr = e.valid ? head.instr : NOP_INSTR;
    e.exc   = e.valid && head.exc;
    e.count = 3'(n);
    e.ready = (n < DEPTH);
    return e;
  endfunction

  // Applies the clock-edge effect of the current inputs to the model.
  task automatic model_commit(input exp_t e);
    bit deq, enq, byp;
    if (fq_if.flush_i) begin
      model_q.delete();
    end else begin
      byp = BYP && (model_q.size() == 0) && fq_if.enq_valid_i;
      deq = e.valid && fq_if.deq_ready_i;
      enq = fq_if.enq_valid_i && (model_q.size() < DEPTH);
      if (!(byp && deq)) begin
        if (deq) void'(model_q.pop_front());
        if (enq) model_q.push_back('{pc: fq_if.enq_pc_i, instr: fq_if.enq_instr_i,
                                     exc: fq_if.enq_exc_i});
      end
    end
    model_last_pc = e.pc;
  endtask

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    checkField({tag, ".deq_valid"}, 32'(fq_if.deq_valid_o), 32'(e.valid));
    checkField({tag, ".deq_pc"}, fq_if.deq_pc_o, e.pc);
    checkField({tag, ".deq_pc_add4"}, fq_if.deq_pc_add4_o, e.add4);
    checkField({tag, ".deq_instr"}, fq_if.deq_instr_o, e.instr);
    checkField({tag, ".deq_exc"}, 32'(fq_if.deq_exc_o), 32'(e.exc));
    checkField({tag, ".count"}, 32'(fq_if.count_o), 32'(e.count));
    checkField({tag, ".enq_ready"}, 32'(fq_if.enq_ready_o), 32'(e.ready));
  endtask

  task automatic applyStimulus(input logic fl, input logic ev, input logic [31:0] pc,
                               input logic [31:0] instr, input logic exc,
                               input logic dr);
    fq_if.flush_i     = fl;
    fq_if.enq_valid_i = ev;
    fq_if.enq_pc_i    = pc;
    fq_if.enq_instr_i = instr;
    fq_if.enq_exc_i   = exc;
    fq_if.deq_ready_i = dr;
  endtask

  // Called 1 time unit after a rising edge; samples at the falling edge.
  task automatic pre_edge(input string tag);
    #4;
    cur_e = model_predict();
    checkOutput(cur_e, tag);
  endtask

  task automatic post_edge();
    @(posedge clk);
    model_commit(cur_e);
    #1;
  endtask

  task automatic run_cycle(input string tag, input logic fl, input logic ev,
                           input logic [31:0] pc, input logic [31:0] instr,
                           input logic exc, input logic dr);
    applyStimulus(fl, ev, pc, instr, exc, dr);
    pre_edge(tag);
    post_edge();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (model_q.size() != 0) run_cycle(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    checkField({tag, ".empty"}, 32'(fq_if.count_o), 32'd0);
  endtask

  initial begin
    // Directed fill/drain and pc+4 wrap vectors; expectations hand-derived.
    vecs[0]  = mk_vec(0, 1, 32'h100, 32'hA0, 0, 0,
                      mk_exp(BYP, BYP ? 32'h100 : 32'h0, BYP ? 32'hA0 : NOP_INSTR, 0, 0, 1));
    vecs[1]  = mk_vec(0, 1, 32'h104, 32'hA1, 0, 0, mk_exp(1, 32'h100, 32'hA0, 0, 1, 1));
    vecs[2]  = mk_vec(0, 1, 32'h108, 32'hA2, 0, 0, mk_exp(1, 32'h100, 32'hA0, 0, 2, 1));
    vecs[3]  = mk_vec(0, 1, 32'h10C, 32'hA3, 0, 0, mk_exp(1, 32'h100, 32'hA0, 0, 3, 1));
    vecs[4]  = mk_vec(0, 1, 32'h110, 32'hA4, 0, 0, mk_exp(1, 32'h100, 32'hA0, 0, 4, 0));
    vecs[5]  = mk_vec(0, 0, 32'h0, 32'h0, 0, 1, mk_exp(1, 32'h100, 32'hA0, 0, 4, 0));
    vecs[6]  = mk_vec(0, 0, 32'h0, 32'h0, 0, 1, mk_exp(1, 32'h104, 32'hA1, 0, 3, 1));
    vecs[7]  = mk_vec(0, 0, 32'h0, 32'h0, 0, 1, mk_exp(1, 32'h108, 32'hA2, 0, 2, 1));
    vecs[8]  = mk_vec(0, 0, 32'h0, 32'h0, 0, 1, mk_exp(1, 32'h10C, 32'hA3, 0, 1, 1));
    vecs[9]  = mk_vec(0, 0, 32'h0, 32'h0, 0, 1, mk_exp(0, 32'h10C, NOP_INSTR, 0, 0, 1));
    vecs[10] = mk_vec(0, 1, 32'hFFFF_FFFC, 32'h55, 1, 0,
                      mk_exp(BYP, BYP ? 32'hFFFF_FFFC : 32'h10C, BYP ? 32'h55 : NOP_INSTR,
                             BYP, 0, 1));
    vecs[11] = mk_vec(0, 0, 32'h0, 32'h0, 0, 1, mk_exp(1, 32'hFFFF_FFFC, 32'h55, 1, 1, 1));
    vecs[12] = mk_vec(0, 0, 32'h0, 32'h0, 0, 0,
                      mk_exp(0, 32'hFFFF_FFFC, NOP_INSTR, 0, 0, 1));

    // Reset state.
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
    #12;
    checkOutput(mk_exp(0, 32'h0, NOP_INSTR, 0, 0, 1), "reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    model_last_pc = 32'h0;

    // Table-driven fill/drain and pc+4 wrap.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].flush, vecs[i].ev, vecs[i].pc, vecs[i].instr,
                    vecs[i].exc, vecs[i].dr);
      #4;
      cur_e = model_predict();
      checkOutput(vecs[i].e, $sformatf("vec%0d", i));
      post_edge();
    end

    // Asynchronous reset in the middle of a cycle with entries queued.
    run_cycle("t1.pre0", 0, 1, 32'h150, 32'hB0, 0, 0);
    run_cycle("t1.pre1", 0, 1, 32'h154, 32'hB1, 1, 0);
    applyStimulus(0, 1, 32'h158, 32'hB2, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput(mk_exp(0, 32'h0, NOP_INSTR, 0, 0, 1), "t1.async");
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    model_last_pc = 32'h0;

    // Simultaneous enq/deq at count 2 across pointer wrap, then full case.
    run_cycle("t3.fill0", 0, 1, 32'h3F8, 32'hC0, 0, 0);
    run_cycle("t3.fill1", 0, 1, 32'h3FC, 32'hC1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      run_cycle($sformatf("t3.both%0d", i), 0, 1, 32'h400 + 32'(4 * i),
                32'hD0 + 32'(i), 0, 1);
    end
    checkField("t3.count_kept", 32'(fq_if.count_o), 32'd2);
    run_cycle("t3.fill2", 0, 1, 32'h500, 32'hE0, 0, 0);
    run_cycle("t3.fill3", 0, 1, 32'h504, 32'hE1, 0, 0);
    run_cycle("t3.full_both", 0, 1, 32'h508, 32'hE2, 0, 1);
    checkField("t3.full_refused", 32'(fq_if.count_o), 32'd3);
    drain("t3.drain");

    // Flush at count 3 with a simultaneous enqueue attempt.
    run_cycle("t4.fill0", 0, 1, 32'h1F0, 32'hF0, 0, 0);
    run_cycle("t4.fill1", 0, 1, 32'h1F4, 32'hF1, 0, 0);
    run_cycle("t4.fill2", 0, 1, 32'h1F8, 32'hF2, 0, 0);
    applyStimulus(1, 1, 32'h200, 32'hF3, 0, 1);
    pre_edge("t4.flush");
    checkField("t4.flush_masked", 32'(fq_if.deq_valid_o), 32'd0);
    post_edge();
    checkField("t4.count_after", 32'(fq_if.count_o), 32'd0);
    for (int i = 0; i < 3; i++) run_cycle($sformatf("t4.after%0d", i), 0, 0, 0, 0, 0, 1);

    // Latency of an enqueue into an empty queue.
    applyStimulus(0, 1, 32'h300, 32'h77, 0, 1);
    pre_edge("t6.enq");
`ifdef FETCH_QUEUE_BYPASS_EN
    checkField("t6.bypass_valid", 32'(fq_if.deq_valid_o), 32'd1);
    checkField("t6.bypass_pc", fq_if.deq_pc_o, 32'h300);
    post_edge();
    checkField("t6.bypass_count", 32'(fq_if.count_o), 32'd0);
`else
    checkField("t6.same_valid", 32'(fq_if.deq_valid_o), 32'd0);
    post_edge();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
    pre_edge("t6.next");
    checkField("t6.next_valid", 32'(fq_if.deq_valid_o), 32'd1);
    checkField("t6.next_pc", fq_if.deq_pc_o, 32'h300);
    post_edge();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      run_cycle($sformatf("rand%0d", i), ($urandom % 16) == 0, ($urandom % 4) != 0,
                $urandom & 32'hFFFF_FFFC, $urandom, ($urandom % 8) == 0,
                ($urandom % 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
